// File: rtl/sc_serial_loader_if.sv
// sc_serial_loader_if: Ex FIFO read port, ASIC slow-control pins and start/status lines of the serial loader.
interface sc_serial_loader_if;
   logic       Start_In;
   logic       In_Ex_Fifo_Empty;
   logic [7:0] In_Ex_Fifo_Dout;
   logic       Out_Ex_Fifo_Rd_En;
   logic       Out_Sr_Ck;
   logic       Out_Sr_In;
   logic       Out_Sr_Rstb;
   logic       Out_Select;
   logic       In_Sr_Out;
   logic       Out_Busy;
   logic       Out_Done;
   logic       Out_Verify_Err;
   logic       Out_Timeout_Err;
   modport master (
      input  Start_In, In_Ex_Fifo_Empty, In_Ex_Fifo_Dout, In_Sr_Out,
      output Out_Ex_Fifo_Rd_En, Out_Sr_Ck, Out_Sr_In, Out_Sr_Rstb, Out_Select,
             Out_Busy, Out_Done, Out_Verify_Err, Out_Timeout_Err
   );
   modport slave (
      output Start_In, In_Ex_Fifo_Empty, In_Ex_Fifo_Dout, In_Sr_Out,
      input  Out_Ex_Fifo_Rd_En, Out_Sr_Ck, Out_Sr_In, Out_Sr_Rstb, Out_Select,
             Out_Busy, Out_Done, Out_Verify_Err, Out_Timeout_Err
   );
endinterface

// File: rtl/sc_serial_loader.sv
// sc_serial_loader: drains the SC image from the Ex FIFO, shifts it into the ASIC SC register and optionally verifies it.
module sc_serial_loader #(
   parameter int SC_BITS      = 616,
   parameter int CLK_DIV      = 4,
   parameter int RST_CYC      = 16,
   parameter int FIFO_TIMEOUT = 1024,
   parameter int VERIFY       = 1
) (
   input logic Clk,
   input logic Rst_N,
   sc_serial_loader_if.master bus
);
   localparam int SC_BYTES = SC_BITS / 8;
   localparam int DW = $clog2(CLK_DIV);
   localparam int TW = $clog2(FIFO_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SR_RESET, LOAD, SHIFT1, SHIFT2, FINISH} state_t;
   state_t state_q, state_d;
   logic [SC_BITS:1] buf_q, buf_d;
   logic [9:0] bit_q, bit_d;
   logic [6:0] rd_q, rd_d, cap_q, cap_d;
   logic [DW-1:0] div_q, div_d;
   logic [TW-1:0] to_q, to_d;
   logic ph_q, ph_d, ck_q, ck_d, sdi_q, sdi_d, rstb_q, rstb_d, sel_q, sel_d;
   logic busy_q, busy_d, done_q, done_d, verr_q, verr_d, terr_q, terr_d;
   logic start_q, vld_q, start, half, rd_en;
   assign start = bus.Start_In & ~start_q;
   assign half  = div_q == DW'(CLK_DIV - 1);
   assign rd_en = state_q == LOAD && !bus.In_Ex_Fifo_Empty && rd_q < 7'(SC_BYTES);
   assign bus.Out_Ex_Fifo_Rd_En = rd_en;
   assign bus.Out_Sr_Ck         = ck_q;
   assign bus.Out_Sr_In         = sdi_q;
   assign bus.Out_Sr_Rstb       = rstb_q;
   assign bus.Out_Select        = sel_q;
   assign bus.Out_Busy          = busy_q;
   assign bus.Out_Done          = done_q;
   assign bus.Out_Verify_Err    = verr_q;
   assign bus.Out_Timeout_Err   = terr_q;
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      bit_d   = bit_q;
      rd_d    = rd_q;
      cap_d   = cap_q;
      div_d   = div_q;
      to_d    = to_q;
      ph_d    = ph_q;
      ck_d    = ck_q;
      sdi_d   = sdi_q;
      rstb_d  = rstb_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      verr_d  = verr_q;
      terr_d  = terr_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SR_RESET;
            verr_d  = 1'b0;
            terr_d  = 1'b0;
            bit_d   = '0;
            rd_d    = '0;
            cap_d   = '0;
            to_d    = '0;
            sel_d   = 1'b1;
            rstb_d  = 1'b0;
            busy_d  = 1'b1;
         end
         SR_RESET: begin
            bit_d = bit_q + 10'd1;
            if (bit_q == 10'(RST_CYC - 1)) begin
               bit_d   = '0;
               rstb_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            rd_d = rd_q + {6'd0, rd_en};
            to_d = rd_en ? '0 : to_q + TW'(1);
            // bytes enter at the LSB end, so byte 0 finishes at the MSBs
            if (vld_q) begin
               buf_d = {buf_q[SC_BITS-8:1], bus.In_Ex_Fifo_Dout};
               cap_d = cap_q + 7'd1;
            end
            if (vld_q && cap_q == 7'(SC_BYTES - 1)) begin
               state_d = SHIFT1;
               sdi_d   = buf_d[SC_BITS];
               div_d   = '0;
               ph_d    = 1'b0;
               ck_d    = 1'b0;
               bit_d   = '0;
            end else if (to_d == TW'(FIFO_TIMEOUT)) begin
               terr_d  = 1'b1;
               state_d = FINISH;
               sel_d   = 1'b0;
               sdi_d   = 1'b0;
               ck_d    = 1'b0;
               done_d  = 1'b1;
            end
         end
         SHIFT1, SHIFT2: begin
            div_d = half ? '0 : div_q + DW'(1);
            if (half && !ph_q) begin
               ph_d = 1'b1;
               ck_d = 1'b1;
               if (state_q == SHIFT2 && bus.In_Sr_Out != buf_q[SC_BITS]) verr_d = 1'b1;
            end
            // rotating keeps the image intact for the second pass
            if (half && ph_q) begin
               ph_d  = 1'b0;
               ck_d  = 1'b0;
               buf_d = {buf_q[SC_BITS-1:1], buf_q[SC_BITS]};
               bit_d = bit_q + 10'd1;
               sdi_d = buf_d[SC_BITS];
               if (bit_q == 10'(SC_BITS - 1)) begin
                  bit_d = '0;
                  if (state_q == SHIFT1 && VERIFY != 0) state_d = SHIFT2;
                  else begin
                     state_d = FINISH;
                     sel_d   = 1'b0;
                     sdi_d   = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state_q <= IDLE;
         buf_q   <= '0;
         bit_q   <= '0;
         rd_q    <= '0;
         cap_q   <= '0;
         div_q   <= '0;
         to_q    <= '0;
         ph_q    <= 1'b0;
         ck_q    <= 1'b0;
         sdi_q   <= 1'b0;
         rstb_q  <= 1'b1;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         verr_q  <= 1'b0;
         terr_q  <= 1'b0;
         start_q <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         bit_q   <= bit_d;
         rd_q    <= rd_d;
         cap_q   <= cap_d;
         div_q   <= div_d;
         to_q    <= to_d;
         ph_q    <= ph_d;
         ck_q    <= ck_d;
         sdi_q   <= sdi_d;
         rstb_q  <= rstb_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         verr_q  <= verr_d;
         terr_q  <= terr_d;
         start_q <= bus.Start_In;
         vld_q   <= rd_en;
      end
   end
endmodule

// File: tb/tb_sc_serial_loader.sv
// tb_sc_serial_loader: random-data bench with a FIFO stream model and a 616-bit ASIC shift-register model.
module tb_sc_serial_loader;
   localparam int SC_BITS = 616;
   localparam int SC_BYTES = 77;
   localparam int CLK_DIV = 4;
   localparam int RST_CYC = 16;
   localparam int FIFO_TIMEOUT = 1024;
   localparam int LAT = RST_CYC + SC_BYTES + 1 + 2 * CLK_DIV * SC_BITS * 2;
   logic Clk = 1'b0;
   logic Rst_N = 1'b0;
   always #5 Clk = ~Clk;
   sc_serial_loader_if bus();
   sc_serial_loader #(.SC_BITS(SC_BITS), .CLK_DIV(CLK_DIV), .RST_CYC(RST_CYC),
                      .FIFO_TIMEOUT(FIFO_TIMEOUT), .VERIFY(1))
      dut (.Clk(Clk), .Rst_N(Rst_N), .bus(bus));
   int n_chk = 0;
   int n_fail = 0;
   // byte stream: src holds every byte ever offered, avail how many are visible
   logic [7:0] src [0:1023];
   int avail = 0;
   int rd_ptr = 0;
   logic [7:0] dout_r = 8'h00;
   assign bus.In_Ex_Fifo_Empty = rd_ptr >= avail;
   assign bus.In_Ex_Fifo_Dout = dout_r;
   always @(posedge Clk) if (bus.Out_Ex_Fifo_Rd_En) begin
      dout_r <= src[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
   end
   logic [SC_BITS-1:0] asic = '0;
   logic sdi_seen [0:2*SC_BITS-1];
   logic ck_prev = 1'b0;
   bit flip_en = 1'b0;
   int rises = 0, cyc = 0, last_rd = 0, done_cyc = 0, done_cnt = 0, rd_empty = 0;
   assign bus.In_Sr_Out = asic[SC_BITS-1] ^ (flip_en && rises == SC_BITS + 4);
   always @(negedge Clk) begin
      cyc <= cyc + 1;
      ck_prev <= bus.Out_Sr_Ck;
      if (!bus.Out_Sr_Rstb) begin
         asic <= '0;
         rises <= 0;
      end else if (bus.Out_Sr_Ck && !ck_prev) begin
         asic <= {asic[SC_BITS-2:0], bus.Out_Sr_In};
         if (rises < 2 * SC_BITS) sdi_seen[rises] <= bus.Out_Sr_In;
         rises <= rises + 1;
      end
      if (bus.Out_Ex_Fifo_Rd_En) last_rd <= cyc;
      if (bus.Out_Ex_Fifo_Rd_En && bus.In_Ex_Fifo_Empty) rd_empty <= rd_empty + 1;
      if (bus.Out_Done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic check_reset_outs(input string tag);
      check(tag, {bus.Out_Ex_Fifo_Rd_En, bus.Out_Sr_Ck, bus.Out_Sr_In, bus.Out_Sr_Rstb, bus.Out_Select,
                  bus.Out_Busy, bus.Out_Done, bus.Out_Verify_Err, bus.Out_Timeout_Err}, 9'b000100000);
   endtask
   task automatic fill(input int n, input bit ramp);
      for (int k = 0; k < n; k++) src[(avail + k) % 1024] = ramp ? 8'(k) : 8'($urandom_range(0, 255));
   endtask
   task automatic do_seq(input string tag, input bit flip, input bit to, input bit chk_lat, output int lat);
      int base, d0, mis1, mis2;
      logic [SC_BITS-1:0] img;
      logic [7:0] first;
      base = rd_ptr;
      d0 = done_cnt;
      flip_en = flip;
      img = '0;
      for (int k = 0; k < SC_BYTES; k++) img[SC_BITS-1-8*k -: 8] = src[(base + k) % 1024];
      @(negedge Clk);
      bus.Start_In = 1'b1;
      lat = 0;
      while (!bus.Out_Done && lat < 15000) begin
         @(negedge Clk);
         lat++;
         if (lat == 2) bus.Start_In = 1'b0;
      end
      check({tag, "_done"}, bus.Out_Done, 1'b1);
      check({tag, "_sel_fin"}, {bus.Out_Select, bus.Out_Sr_Ck, bus.Out_Sr_In, bus.Out_Busy}, 4'b0001);
      if (chk_lat) check({tag, "_lat"}, 64'(lat >= LAT && lat <= LAT + 6), 1);
      repeat (3) @(negedge Clk);
      check({tag, "_ndone"}, done_cnt - d0, 1);
      check({tag, "_idle"}, bus.Out_Busy, 1'b0);
      check({tag, "_reads"}, rd_ptr - base, to ? 40 : SC_BYTES);
      check({tag, "_terr"}, bus.Out_Timeout_Err, to);
      check({tag, "_verr"}, bus.Out_Verify_Err, flip);
      check({tag, "_rises"}, rises, to ? 0 : 2 * SC_BITS);
      if (to) check({tag, "_gap"}, 64'(done_cyc - last_rd >= FIFO_TIMEOUT && done_cyc - last_rd <= FIFO_TIMEOUT + 3), 1);
      else begin
         mis1 = 0;
         mis2 = 0;
         for (int n = 0; n < SC_BITS; n++) begin
            if (sdi_seen[n] !== img[SC_BITS-1-n]) mis1++;
            if (sdi_seen[SC_BITS+n] !== img[SC_BITS-1-n]) mis2++;
         end
         for (int n = 0; n < 8; n++) first[7-n] = sdi_seen[n];
         check({tag, "_first8"}, first, src[base % 1024]);
         check({tag, "_pass1"}, mis1, 0);
         check({tag, "_pass2"}, mis2, 0);
         check({tag, "_image"}, $countones(asic ^ img), 0);
      end
      flip_en = 1'b0;
   endtask
   initial begin
      int lat1, lat2, lat, w, d0, base;
      bus.Start_In = 1'b0;
      repeat (3) @(negedge Clk);
      check_reset_outs("reset");
      Rst_N = 1'b1;
      repeat (3) @(negedge Clk);
      check("idle_busy", bus.Out_Busy, 1'b0);
      fill(SC_BYTES, 1'b1);
      avail += SC_BYTES;
      do_seq("t1", 1'b0, 1'b0, 1'b1, lat1);
      fill(SC_BYTES, 1'b0);
      avail += SC_BYTES;
      do_seq("t2", 1'b1, 1'b0, 1'b1, lat2);
      check("t2_samelen", lat2, lat1);
      fill(40, 1'b0);
      avail += 40;
      do_seq("t3", 1'b0, 1'b1, 1'b0, lat);
      fill(SC_BYTES, 1'b0);
      fork
         do_seq("t4", 1'b0, 1'b0, 1'b0, lat);
         repeat (SC_BYTES) begin
            repeat (20) @(negedge Clk);
            avail++;
         end
      join
      check("t4_rd_empty", rd_empty, 0);
      fill(SC_BYTES, 1'b0);
      avail += SC_BYTES;
      d0 = done_cnt;
      @(negedge Clk);
      bus.Start_In = 1'b1;
      w = 0;
      while (rises < 300 && w < 20000) begin
         @(negedge Clk);
         w++;
      end
      check("t5_reach", 64'(rises >= 300), 1);
      bus.Start_In = 1'b0;
      #2 Rst_N = 1'b0;
      #1 check_reset_outs("t5_async");
      repeat (3) @(negedge Clk);
      Rst_N = 1'b1;
      repeat (3) @(negedge Clk);
      check("t5_nodone", done_cnt - d0, 0);
      fill(SC_BYTES, 1'b0);
      avail += SC_BYTES;
      do_seq("t5b", 1'b0, 1'b0, 1'b1, lat);
      fill(SC_BYTES, 1'b0);
      avail += SC_BYTES;
      base = rd_ptr;
      d0 = done_cnt;
      @(negedge Clk);
      bus.Start_In = 1'b1;
      w = 0;
      while (rises < 50 && w < 20000) begin
         @(negedge Clk);
         w++;
      end
      bus.Start_In = 1'b0;
      repeat (5) @(negedge Clk);
      bus.Start_In = 1'b1;
      repeat (5) @(negedge Clk);
      bus.Start_In = 1'b0;
      repeat (5) @(negedge Clk);
      bus.Start_In = 1'b1;
      w = 0;
      while (!bus.Out_Done && w < 15000) begin
         @(negedge Clk);
         w++;
      end
      repeat (200) @(negedge Clk);
      check("t6_onedone", done_cnt - d0, 1);
      check("t6_idle", bus.Out_Busy, 1'b0);
      check("t6_reads", rd_ptr - base, SC_BYTES);
      check("t6_verr", bus.Out_Verify_Err, 1'b0);
      bus.Start_In = 1'b0;
      repeat (2) @(negedge Clk);
      fill(SC_BYTES, 1'b0);
      avail += SC_BYTES;
      do_seq("t6b", 1'b0, 1'b0, 1'b1, lat);
      check("rd_empty_all", rd_empty, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
